// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline control slice.
//   reg_t        : architectural register index, also used by the hazard unit
//   ctrl_state_t : fetch-drain state of the pipeline control unit
//   CNT_W_DEFAULT: default width of the optional performance counters
package pipeline_ctrl_unit_pkg;

    typedef logic [4:0] reg_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

    localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Handshake/control bundle between the pipeline control unit and its neighbours
// (hazard unit, fetch interface, data memory, pipeline registers).
//   slave  modport: used by pipeline_ctrl_unit (consumes requests, drives controls)
//   master modport: used by the surrounding pipeline / testbench
// Optional macro PIPE_PERF_CNT_EN adds o_stall_cnt / o_flush_cnt.
interface pipeline_ctrl_unit_if
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic i_hz_stall;
    logic i_EX_redirect;
    logic i_dmem_busy;
    logic i_imem_valid;

    logic o_if_ack;
    logic o_pc_en;
    logic o_IFID_en;
    logic o_IFID_flush;
    logic o_IDEX_en;
    logic o_IDEX_bubble;
    logic o_EXMEM_en;
    logic o_MEMWB_bubble;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;
`endif

    modport slave (
        input  i_hz_stall,
        input  i_EX_redirect,
        input  i_dmem_busy,
        input  i_imem_valid,
        output o_if_ack,
        output o_pc_en,
        output o_IFID_en,
        output o_IFID_flush,
        output o_IDEX_en,
        output o_IDEX_bubble,
        output o_EXMEM_en,
        output o_MEMWB_bubble
`ifdef PIPE_PERF_CNT_EN
        ,
        output o_stall_cnt,
        output o_flush_cnt
`endif
    );

    modport master (
        output i_hz_stall,
        output i_EX_redirect,
        output i_dmem_busy,
        output i_imem_valid,
        input  o_if_ack,
        input  o_pc_en,
        input  o_IFID_en,
        input  o_IFID_flush,
        input  o_IDEX_en,
        input  o_IDEX_bubble,
        input  o_EXMEM_en,
        input  o_MEMWB_bubble
`ifdef PIPE_PERF_CNT_EN
        ,
        input  o_stall_cnt,
        input  o_flush_cnt
`endif
    );

endinterface

// File: rtl/pipeline_ctrl_unit_perf_counter.sv
// perf_counter: free-running wrap-around event counter.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : add one this cycle
//   count_o : current count, wraps modulo 2^Width
module perf_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: per-stage enable/flush/bubble control for the 5-stage RV32I pipeline.
// Combines the hazard unit's load-use stall, the EX redirect, data-memory busy and the
// fetch response handshake. A one-bit state (RUN/DRAIN) discards the wrong-path fetch
// response that is still in flight after a redirect.
// Ports:
//   i_clk  : core clock
//   i_rstn : asynchronous active-low reset
//   bus    : pipeline_ctrl_unit_if.slave (stall/redirect/busy/valid in; controls out)
// Optional macro PIPE_PERF_CNT_EN adds stall and redirect counters (CNT_W bits).
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    pipeline_ctrl_unit_if.slave  bus
);

    ctrl_state_t st_q;
    ctrl_state_t st_d;

    logic if_ack;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_bubble;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            st_q <= RUN;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        if_ack       = 1'b0;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;

        if (!i_rstn) begin
            // Outputs follow reset combinationally so the pipe fills with bubbles.
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (bus.i_dmem_busy) begin
            // Whole pipe frozen; only MEM/WB drains a bubble. Redirect and stall
            // stay asserted upstream because EX and ID are held.
            memwb_bubble = 1'b1;
        end else if (bus.i_EX_redirect) begin
            // Any response present now is wrong-path: ack and drop it. Without one,
            // the wrong-path response is still coming and must be drained.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            if_ack      = bus.i_imem_valid;
            st_d        = bus.i_imem_valid ? RUN : DRAIN;
        end else if (st_q == DRAIN) begin
            // Waiting for the stale response; PC already points at the target.
            if_ack   = bus.i_imem_valid;
            exmem_en = 1'b1;
            idex_en  = 1'b1;
            if (bus.i_hz_stall) begin
                idex_bubble = 1'b1;
            end else begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
            end
            if (bus.i_imem_valid) begin
                st_d = RUN;
            end
        end else if (bus.i_hz_stall) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
        end else if (!bus.i_imem_valid) begin
            // Fetch not back yet: keep PC, feed a NOP into decode.
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_ack   = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
        end
    end

    assign bus.o_if_ack       = if_ack;
    assign bus.o_pc_en        = pc_en;
    assign bus.o_IFID_en      = ifid_en;
    assign bus.o_IFID_flush   = ifid_flush;
    assign bus.o_IDEX_en      = idex_en;
    assign bus.o_IDEX_bubble  = idex_bubble;
    assign bus.o_EXMEM_en     = exmem_en;
    assign bus.o_MEMWB_bubble = memwb_bubble;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    // Stall cycles: freeze, or a load-use stall that is not overridden by a redirect
    // (covers the stall both in RUN and in DRAIN).
    always_comb begin
        stall_inc = bus.i_dmem_busy || (!bus.i_EX_redirect && bus.i_hz_stall);
        flush_inc = !bus.i_dmem_busy && bus.i_EX_redirect;
    end

    perf_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .inc_i   (stall_inc),
        .count_o (bus.o_stall_cnt)
    );

    perf_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .inc_i   (flush_inc),
        .count_o (bus.o_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Testbench for pipeline_ctrl_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a table-driven model of the control rules.
module tb_pipeline_ctrl_unit;

    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rstn;

    int n_checks = 0;
    int n_err    = 0;

    pipeline_ctrl_unit_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl_unit #(
        .CNT_W (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector order: pc_en, if_ack, IFID_en, IFID_flush, IDEX_en, IDEX_bubble,
    // EXMEM_en, MEMWB_bubble.
    function automatic logic [7:0] dut_outs();
        return {bus.o_pc_en, bus.o_if_ack, bus.o_IFID_en, bus.o_IFID_flush,
                bus.o_IDEX_en, bus.o_IDEX_bubble, bus.o_EXMEM_en, bus.o_MEMWB_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Situation index: 0 reset, 1 freeze, 2 redirect, 3 drain, 4 load-use, 5 no fetch, 6 normal.
    function automatic int classify(logic r, logic b, logic x, logic drain, logic h, logic v);
        if (!r) return 0;
        if (b) return 1;
        if (x) return 2;
        if (drain) return 3;
        if (h) return 4;
        if (!v) return 5;
        return 6;
    endfunction

    function automatic logic [7:0] expect_outs(int c, logic h, logic v);
        case (c)
            0: return 8'b0001_0101;
            1: return 8'b0000_0001;
            2: return {1'b1, v, 6'b11_1110};
            3: return h ? {1'b0, v, 6'b00_1110} : {1'b0, v, 6'b11_1010};
            4: return 8'b0000_1110;
            5: return 8'b0011_1010;
            default: return 8'b1110_1010;
        endcase
    endfunction

    logic        m_drain;
    logic        m_drain_next = 1'b0;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic        m_stall_inc = 1'b0;
    logic        m_flush_inc = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_drain <= 1'b0;
            m_stall <= '0;
            m_flush <= '0;
        end else begin
            m_drain <= m_drain_next;
            m_stall <= m_stall + {31'd0, m_stall_inc};
            m_flush <= m_flush + {31'd0, m_flush_inc};
        end
    end

    // Compare process: inputs are stable around the falling edge.
    always @(negedge clk) begin
        int c;
        c = classify(rstn, bus.i_dmem_busy, bus.i_EX_redirect, m_drain,
                     bus.i_hz_stall, bus.i_imem_valid);
        check("model_outs", {24'd0, dut_outs()},
              {24'd0, expect_outs(c, bus.i_hz_stall, bus.i_imem_valid)});
`ifdef PIPE_PERF_CNT_EN
        check("model_stall_cnt", bus.o_stall_cnt, m_stall);
        check("model_flush_cnt", bus.o_flush_cnt, m_flush);
`endif
        case (c)
            0:       m_drain_next = 1'b0;
            2, 3:    m_drain_next = !bus.i_imem_valid;
            default: m_drain_next = m_drain;
        endcase
        m_stall_inc = (c == 1) || (c == 4) || (c == 3 && bus.i_hz_stall);
        m_flush_inc = (c == 2);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic b, input logic x, input logic h,
                       input logic v, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1;
        rstn              = r;
        bus.i_dmem_busy   = b;
        bus.i_EX_redirect = x;
        bus.i_hz_stall    = h;
        bus.i_imem_valid  = v;
        @(negedge clk);
        #1;
        check(name, {24'd0, dut_outs()}, {24'd0, exp});
    endtask

    initial begin
        rstn              = 1'b0;
        bus.i_dmem_busy   = 1'b0;
        bus.i_EX_redirect = 1'b0;
        bus.i_hz_stall    = 1'b0;
        bus.i_imem_valid  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", {24'd0, dut_outs()}, 32'h15);

        // Release reset: first cycle is normal.
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "first_normal");
`ifdef PIPE_PERF_CNT_EN
        check("cnt_stall_zero", bus.o_stall_cnt, 32'd0);
        check("cnt_flush_zero", bus.o_flush_cnt, 32'd0);
`endif

        // Load-use stall in RUN.
        cyc(1, 0, 0, 1, 1, 8'b0000_1110, "run_hz_stall");
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "after_stall_normal");
`ifdef PIPE_PERF_CNT_EN
        check("cnt_stall_one", bus.o_stall_cnt, 32'd1);
`endif

        // RUN without a fetch response.
        cyc(1, 0, 0, 0, 0, 8'b0011_1010, "run_no_valid");

        // Redirect with no response in flight -> DRAIN, two empty cycles, then drop.
        cyc(1, 0, 1, 0, 0, 8'b1011_1110, "redirect_novalid");
        cyc(1, 0, 0, 0, 0, 8'b0011_1010, "drain_wait1");
        cyc(1, 0, 0, 0, 0, 8'b0011_1010, "drain_wait2");
        cyc(1, 0, 0, 0, 1, 8'b0111_1010, "drain_drop");
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "back_to_run");
`ifdef PIPE_PERF_CNT_EN
        check("cnt_flush_one", bus.o_flush_cnt, 32'd1);
`endif

        // Freeze while a redirect is pending in DRAIN; redirect applied once after.
        cyc(1, 0, 1, 0, 0, 8'b1011_1110, "redirect_to_drain");
        cyc(1, 1, 1, 0, 0, 8'b0000_0001, "freeze1");
        cyc(1, 1, 1, 1, 0, 8'b0000_0001, "freeze2");
        cyc(1, 1, 1, 0, 1, 8'b0000_0001, "freeze3");
        cyc(1, 0, 1, 0, 0, 8'b1011_1110, "redirect_after_freeze");
        cyc(1, 0, 0, 0, 0, 8'b0011_1010, "still_drain");

        // Load-use stall while draining.
        cyc(1, 0, 0, 1, 0, 8'b0000_1110, "drain_hz_stall");
        cyc(1, 0, 0, 1, 1, 8'b0100_1110, "drain_hz_drop");
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "run_after_drain_hz");

        // Redirect with response present stays RUN; back-to-back redirect without -> DRAIN.
        cyc(1, 0, 1, 1, 1, 8'b1111_1110, "redirect_valid");
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "run_after_redir_valid");
        cyc(1, 0, 1, 0, 1, 8'b1111_1110, "redirect_valid2");
        cyc(1, 0, 1, 0, 0, 8'b1011_1110, "redirect_b2b_novalid");
        cyc(1, 0, 0, 0, 0, 8'b0011_1010, "drain_after_b2b");

        // Asynchronous reset in the middle of DRAIN.
        @(posedge clk);
        #1;
        bus.i_EX_redirect = 1'b0;
        bus.i_hz_stall    = 1'b0;
        bus.i_imem_valid  = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outs", {24'd0, dut_outs()}, 32'h15);
        @(negedge clk);
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "run_after_async_reset");
`ifdef PIPE_PERF_CNT_EN
        check("cnt_stall_cleared", bus.o_stall_cnt, 32'd0);
        check("cnt_flush_cleared", bus.o_flush_cnt, 32'd0);
`endif
        cyc(1, 0, 0, 0, 1, 8'b1110_1010, "final_normal");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
- Consumer of the load-use stall request from the hazard detection unit.
- Combines that stall with the EX-stage branch/jump redirect, data-memory busy and instruction-fetch response handshake. From these it drives the per-stage enable, flush and bubble controls of the 5-stage RV32I pipeline.
- Holds a small state machine that discards a wrong-path fetch still in flight after a redirect.
- Sits beside the hazard unit, between the fetch interface and the pipeline registers.

Parameters:
- CNT_W, 32, width of the optional performance counters.

Ports:
- i_clk, input, 1, core clock.
- i_rstn, input, 1, asynchronous active-low reset.
- i_hz_stall, input, 1, load-use stall request from the hazard detection unit.
- i_EX_redirect, input, 1, taken branch/jump resolved in EX; the PC mux selects the target externally.
- i_dmem_busy, input, 1, data memory has not completed the MEM-stage access.
- i_imem_valid, input, 1, fetch response present; it is held until acked.
- o_if_ack, output, 1, fetch response consumed this cycle.
- o_pc_en, output, 1, PC register load enable.
- o_IFID_en, output, 1, IF/ID register enable.
- o_IFID_flush, output, 1, IF/ID loads a NOP bubble (only takes effect with o_IFID_en=1).
- o_IDEX_en, output, 1, ID/EX register enable.
- o_IDEX_bubble, output, 1, ID/EX loads a bubble (control bits zeroed).
- o_EXMEM_en, output, 1, EX/MEM register enable.
- o_MEMWB_bubble, output, 1, MEM/WB loads a bubble.
- o_stall_cnt, output, CNT_W, stall cycles (optional feature only).
- o_flush_cnt, output, CNT_W, redirects (optional feature only).

Behaviour:
- State register st ∈ {RUN, DRAIN}; the reset value is RUN. It is the only state besides the optional counters.
- All outputs are combinational from st and the inputs, and take effect in the same cycle.
- While i_rstn=0:
  - all enables and o_if_ack are 0;
  - o_IFID_flush, o_IDEX_bubble and o_MEMWB_bubble are 1.
- Priority per cycle, highest first.
- 1. Freeze (i_dmem_busy=1):
  - o_pc_en, o_IFID_en, o_IDEX_en, o_EXMEM_en and o_if_ack are 0; o_MEMWB_bubble=1; flush and bubble outputs are otherwise 0;
  - st holds;
  - i_EX_redirect and i_hz_stall are ignored; both stay asserted because EX and ID are frozen.
- 2. Redirect (i_EX_redirect=1):
  - o_pc_en=1, o_IFID_en=1, o_IFID_flush=1, o_IDEX_en=1, o_IDEX_bubble=1, o_EXMEM_en=1;
  - o_if_ack=i_imem_valid; the acked response is discarded;
  - next st is RUN if i_imem_valid=1, otherwise DRAIN;
  - a redirect while in DRAIN keeps or returns DRAIN by the same rule;
  - i_hz_stall is ignored, because the ID instruction is wrong-path.
- 3. st=DRAIN, no redirect:
  - o_pc_en=0; o_if_ack=i_imem_valid (stale response discarded);
  - if i_hz_stall=1: o_IFID_en=0, o_IDEX_en=1, o_IDEX_bubble=1;
  - otherwise: o_IFID_en=1, o_IFID_flush=1, o_IDEX_en=1;
  - o_EXMEM_en=1;
  - i_imem_valid=1 moves st to RUN.
- 4. st=RUN, i_hz_stall=1:
  - o_pc_en=0, o_IFID_en=0, o_if_ack=0, o_IDEX_en=1, o_IDEX_bubble=1, o_EXMEM_en=1.
- 5. st=RUN, i_imem_valid=0:
  - o_pc_en=0, o_if_ack=0, o_IFID_en=1, o_IFID_flush=1, o_IDEX_en=1, o_EXMEM_en=1.
- 6. st=RUN, normal:
  - o_pc_en, o_if_ack, o_IFID_en, o_IDEX_en and o_EXMEM_en are 1; all flush and bubble outputs are 0.
- Invariants:
  - at most one fetch is outstanding;
  - o_pc_en=1 implies o_if_ack=1, except under redirect;
  - o_MEMWB_bubble=1 only under freeze or reset.
- Reset mid-DRAIN returns to RUN; the fetch unit must also drop its outstanding request on reset.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments on every cycle matching case 1, or case 4, or case 3 with i_hz_stall=1;
  - o_flush_cnt increments on every case-2 cycle;
  - both are CNT_W bits, wrap modulo 2^CNT_W, and reset to 0.
- Undefined: both ports are absent and no counter flops exist.

Decomposition:
- Shared package:
  - reg_t, already used by the hazard unit;
  - new enum ctrl_state_t {RUN, DRAIN};
  - CNT_W default constant.
- Sub-module: perf_counter (saturation-free CNT_W counter with increment enable), instantiated twice under PIPE_PERF_CNT_EN.

Test Plan:
- Reset with i_imem_valid=1 and i_hz_stall=0, release → first cycle is case 6: o_pc_en=1, o_if_ack=1, no bubbles; counters 0.
- i_hz_stall=1 for 1 cycle in RUN with i_imem_valid=1 → o_pc_en=0, o_IFID_en=0, o_if_ack=0, o_IDEX_bubble=1; next cycle normal; o_stall_cnt=1.
- i_EX_redirect=1 with i_imem_valid=0 → flush, bubble and o_pc_en=1, st→DRAIN. The next 2 cycles with valid=0 give o_IFID_flush=1 and o_pc_en=0. Then valid=1 → o_if_ack=1 with the response dropped, st→RUN; o_flush_cnt=1.
- i_dmem_busy=1 for 3 cycles while i_EX_redirect=1 and st=DRAIN → all enables 0 and o_MEMWB_bubble=1 for 3 cycles, st stays DRAIN. On release the redirect is applied once.
- Redirect with i_imem_valid=1 → o_if_ack=1 same cycle, st stays RUN; a second redirect the following cycle with valid=0 → DRAIN.
- Async reset asserted mid-DRAIN → outputs go to reset values immediately; after release st=RUN.
